// File: rtl/snake_pkg.sv
// snake_pkg: shared coordinate type, food placer states and default grid size
package snake_pkg;
   typedef logic [3:0] coord_t;
   typedef enum logic [2:0] {IDLE, REQ, WAIT, QUERY, CHECK, SCAN_Q, SCAN_C} food_state_t;
   localparam int GRID_W = 16;
   localparam int GRID_H = 12;
endpackage

// File: rtl/grid_scan_counter.sv
// grid_scan_counter: x-fastest raster position over the playable grid for the fallback scan
module grid_scan_counter
   import snake_pkg::*;
#(
   parameter int GRID_W = snake_pkg::GRID_W,
   parameter int GRID_H = snake_pkg::GRID_H
) (
   input  logic       system_clk,
   input  logic       nreset,
   input  logic       clear,
   input  logic       step,
   output logic [3:0] next_x,
   output logic [3:0] next_y,
   output logic       last
);
   coord_t x, y;
   logic wrap;
   // current scan cell; clear restarts at (0,0)
   always_ff @(posedge system_clk or negedge nreset)
      if (!nreset) begin
         x <= '0;
         y <= '0;
      end else if (clear) begin
         x <= '0;
         y <= '0;
      end else if (step) begin
         x <= next_x;
         y <= next_y;
      end
   // successor cell and end-of-grid flag for the current cell
   always_comb begin
      wrap = x == coord_t'(GRID_W - 1);
      next_x = wrap ? '0 : x + 4'd1;
      next_y = wrap ? y + 4'd1 : y;
      last = wrap && y == coord_t'(GRID_H - 1);
   end
endmodule

// File: rtl/food_placer.sv
// food_placer: draws random cells, rejects off-grid/occupied ones, falls back to a raster scan
module food_placer
   import snake_pkg::*;
#(
   parameter int GRID_W    = snake_pkg::GRID_W,
   parameter int GRID_H    = snake_pkg::GRID_H,
   parameter int MAX_TRIES = 16,
   parameter int SETTLE    = 2
) (
   input  logic       system_clk,
   input  logic       nreset,
   input  logic       place_req,
   input  logic [7:0] rand_num,
   output logic       rng_enable,
   output logic [3:0] occ_x,
   output logic [3:0] occ_y,
   input  logic       occ_hit,
   output logic [3:0] food_x,
   output logic [3:0] food_y,
   output logic       food_valid,
   output logic       busy,
   output logic       board_full
);
   food_state_t state, state_d;
   logic [7:0] tries, tries_d, tries_inc, settle_cnt, settle_cnt_d;
   coord_t occ_x_d, occ_y_d, food_x_d, food_y_d, scan_x, scan_y;
   logic rng_enable_d, food_valid_d, board_full_d;
   logic scan_clear, scan_step, scan_last;
   logic settle_done, off_grid, give_up, reject, commit;

   grid_scan_counter #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_scan (
      .system_clk(system_clk),
      .nreset(nreset),
      .clear(scan_clear),
      .step(scan_step),
      .next_x(scan_x),
      .next_y(scan_y),
      .last(scan_last)
   );

   // state and every output are registered
   always_ff @(posedge system_clk or negedge nreset)
      if (!nreset) begin
         state      <= IDLE;
         tries      <= '0;
         settle_cnt <= '0;
         rng_enable <= 1'b0;
         occ_x      <= '0;
         occ_y      <= '0;
         food_x     <= '0;
         food_y     <= '0;
         food_valid <= 1'b0;
         board_full <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_d;
         tries      <= tries_d;
         settle_cnt <= settle_cnt_d;
         rng_enable <= rng_enable_d;
         occ_x      <= occ_x_d;
         occ_y      <= occ_y_d;
         food_x     <= food_x_d;
         food_y     <= food_y_d;
         food_valid <= food_valid_d;
         board_full <= board_full_d;
         busy       <= state_d != IDLE;
      end

   // next state; the candidate lives in occ_x/occ_y from capture until commit
   always_comb begin
      state_d      = state;
      tries_d      = tries;
      settle_cnt_d = settle_cnt;
      rng_enable_d = 1'b0;
      occ_x_d      = occ_x;
      occ_y_d      = occ_y;
      food_x_d     = food_x;
      food_y_d     = food_y;
      food_valid_d = food_valid;
      board_full_d = board_full;
      scan_clear   = 1'b0;
      scan_step    = 1'b0;
      tries_inc    = tries >= 8'(MAX_TRIES - 1) ? 8'(MAX_TRIES) : tries + 8'd1;
      give_up      = tries_inc == 8'(MAX_TRIES);
      settle_done  = settle_cnt == 8'(SETTLE - 1);
      off_grid     = {1'b0, rand_num[7:4]} >= 5'(GRID_W) || {1'b0, rand_num[3:0]} >= 5'(GRID_H);
      reject       = (state == WAIT && settle_done && off_grid) || (state == CHECK && occ_hit);
      commit       = (state == CHECK || state == SCAN_C) && !occ_hit;
      case (state)
         IDLE: if (place_req) begin
            state_d      = REQ;
            rng_enable_d = 1'b1;
            tries_d      = '0;
            food_valid_d = 1'b0;
            board_full_d = 1'b0;
         end
         REQ: begin
            state_d      = WAIT;
            settle_cnt_d = '0;
         end
         WAIT: if (!settle_done) settle_cnt_d = settle_cnt + 8'd1;
            else if (!off_grid) begin
               occ_x_d = rand_num[7:4];
               occ_y_d = rand_num[3:0];
               state_d = QUERY;
            end
         QUERY: state_d = CHECK;
         SCAN_Q: state_d = SCAN_C;
         SCAN_C: if (occ_hit && scan_last) begin
               board_full_d = 1'b1;
               state_d      = IDLE;
            end else if (occ_hit) begin
               scan_step = 1'b1;
               occ_x_d   = scan_x;
               occ_y_d   = scan_y;
               state_d   = SCAN_Q;
            end
         default: ;
      endcase
      if (commit) begin
         food_x_d     = occ_x;
         food_y_d     = occ_y;
         food_valid_d = 1'b1;
         state_d      = IDLE;
      end
      if (reject) begin
         tries_d      = tries_inc;
         rng_enable_d = !give_up;
         scan_clear   = give_up;
         state_d      = give_up ? SCAN_Q : REQ;
         if (give_up) begin
            occ_x_d = '0;
            occ_y_d = '0;
         end
      end
   end
endmodule

// File: tb/tb_food_placer.sv
// tb_food_placer: outcome/latency reference model with per-cycle compare plus directed pins
module tb_food_placer;
   localparam int W = 16, H = 12, MT = 4, ST = 2;
   logic system_clk = 1'b0, nreset = 1'b1, place_req = 1'b0, occ_hit = 1'b0;
   logic [7:0] rand_num = '0;
   logic rng_enable, food_valid, busy, board_full;
   logic [3:0] occ_x, occ_y, food_x, food_y;
   int nvec = 0, nbad = 0, pulses = 0, rng_idx = 0, cyc = 0, done = -1;
   logic [7:0] seq [4096];
   bit occmap [16][16];
   bit e_busy, e_valid, e_full, p_found;
   logic [3:0] e_fx = '0, e_fy = '0, p_x, p_y;
   bit rng_at [int];
   logic [7:0] occ_at [int];

   food_placer #(.GRID_W(W), .GRID_H(H), .MAX_TRIES(MT), .SETTLE(ST)) dut (
      .system_clk(system_clk), .nreset(nreset), .place_req(place_req), .rand_num(rand_num),
      .rng_enable(rng_enable), .occ_x(occ_x), .occ_y(occ_y), .occ_hit(occ_hit),
      .food_x(food_x), .food_y(food_y), .food_valid(food_valid), .busy(busy), .board_full(board_full)
   );

   always #5 system_clk = ~system_clk;

   // random source: next sequence value appears on the edge that sees the enable
   always @(posedge system_clk) if (rng_enable) begin
      rand_num <= seq[rng_idx];
      rng_idx <= rng_idx + 1;
      pulses <= pulses + 1;
   end

   // body occupancy lookup, one cycle read latency
   always @(posedge system_clk) occ_hit <= occmap[occ_x][occ_y];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
      end
   endtask

   // outcome of one placement: which cell, and on which edge it lands
   task automatic plan();
      int t = 0, x, y;
      logic [7:0] v;
      p_found = 0;
      for (int k = 0; k < MT; k++) begin
         v = seq[rng_idx + k];
         x = int'(v[7:4]);
         y = int'(v[3:0]);
         rng_at[cyc + t] = 1;
         if (x < W && y < H) begin
            occ_at[cyc + t + 1 + ST] = v;
            t += ST + 3;
            if (!occmap[x][y]) begin
               p_found = 1; p_x = 4'(x); p_y = 4'(y); done = cyc + t;
               return;
            end
         end else t += ST + 1;
      end
      for (int c = 0; c < W * H; c++) begin
         t += 2;
         if (!occmap[c % W][c / W]) begin
            p_found = 1; p_x = 4'(c % W); p_y = 4'(c / W); done = cyc + t;
            return;
         end
      end
      done = cyc + t;
   endtask

   initial forever begin
      @(posedge system_clk or negedge nreset);
      if (!nreset) begin
         e_busy = 0; e_valid = 0; e_full = 0; e_fx = '0; e_fy = '0; done = -1;
         rng_at.delete();
         occ_at.delete();
      end else begin
         cyc++;
         if (cyc == done) begin
            e_busy = 0; e_valid = p_found; e_full = !p_found;
            if (p_found) begin e_fx = p_x; e_fy = p_y; end
         end else if (place_req && cyc > done) begin
            e_busy = 1; e_valid = 0; e_full = 0;
            plan();
         end
      end
   end

   initial forever begin
      @(negedge system_clk);
      if (nreset) begin
         chk("busy", 32'(busy), 32'(e_busy));
         chk("food_valid", 32'(food_valid), 32'(e_valid));
         chk("board_full", 32'(board_full), 32'(e_full));
         chk("food_x", 32'(food_x), 32'(e_fx));
         chk("food_y", 32'(food_y), 32'(e_fy));
         chk("rng_enable", 32'(rng_enable), 32'(rng_at.exists(cyc)));
         if (occ_at.exists(cyc)) chk("occ_addr", 32'({occ_x, occ_y}), 32'(occ_at[cyc]));
      end
   end

   task automatic fill_occ(input int pct);
      for (int x = 0; x < 16; x++)
         for (int y = 0; y < 16; y++) occmap[x][y] = $urandom_range(0, 99) < pct;
   endtask

   task automatic do_req(input int spam_at, output int n);
      @(negedge system_clk) place_req = 1'b1;
      @(negedge system_clk) place_req = 1'b0;
      n = 0;
      while (busy && n < 2000) begin
         n++;
         place_req = n == spam_at;
         @(negedge system_clk);
      end
      place_req = 1'b0;
      chk("settle_budget", 32'(busy), 0);
   endtask

   task automatic rst_vals(input string nm);
      chk({nm, "_busy"}, 32'(busy), 0);
      chk({nm, "_rng"}, 32'(rng_enable), 0);
      chk({nm, "_occ"}, 32'({occ_x, occ_y}), 0);
      chk({nm, "_food"}, 32'({food_x, food_y}), 0);
      chk({nm, "_valid"}, 32'(food_valid), 0);
      chk({nm, "_full"}, 32'(board_full), 0);
   endtask

   initial begin
      int n, p;
      for (int i = 0; i < 4096; i++) seq[i] = 8'($urandom_range(0, 255));
      #1 nreset = 1'b0;
      #11 rst_vals("reset");
      @(negedge system_clk) nreset = 1'b1;
      fill_occ(0);
      seq[rng_idx] = 8'h35; p = pulses;
      do_req(0, n);
      chk("happy_edges", n, 5);
      chk("happy_cell", 32'({food_x, food_y}), 32'h35);
      chk("happy_valid", 32'(food_valid), 1);
      chk("happy_pulses", pulses - p, 1);
      seq[rng_idx] = 8'h3C; seq[rng_idx + 1] = 8'h21; p = pulses;
      do_req(0, n);
      chk("offgrid_edges", n, 8);
      chk("offgrid_cell", 32'({food_x, food_y}), 32'h21);
      chk("offgrid_pulses", pulses - p, 2);
      occmap[4][4] = 1;
      seq[rng_idx] = 8'h44; seq[rng_idx + 1] = 8'h62; p = pulses;
      do_req(0, n);
      chk("occupied_busy_edges", n, 10);
      chk("occupied_cell", 32'({food_x, food_y}), 32'h62);
      chk("occupied_pulses", pulses - p, 2);
      seq[rng_idx] = 8'h35;
      @(negedge system_clk) place_req = 1'b1;
      @(negedge system_clk) place_req = 1'b0;
      @(negedge system_clk);
      #2 nreset = 1'b0;
      #1 rst_vals("wait_reset");
      @(negedge system_clk) nreset = 1'b1;
      fill_occ(0);
      occmap[0][0] = 1; occmap[1][0] = 1; occmap[1][1] = 1;
      occmap[2][2] = 1; occmap[3][3] = 1; occmap[4][4] = 1;
      seq[rng_idx] = 8'h11; seq[rng_idx + 1] = 8'h22;
      seq[rng_idx + 2] = 8'h33; seq[rng_idx + 3] = 8'h44; p = pulses;
      do_req(0, n);
      chk("fallback_edges", n, 26);
      chk("fallback_cell", 32'({food_x, food_y}), 32'h20);
      chk("fallback_pulses", pulses - p, 4);
      fill_occ(100); p = pulses;
      for (int i = 0; i < 4; i++) seq[rng_idx + i] = 8'h77;
      do_req(0, n);
      chk("full_edges", n, 404);
      chk("full_flag", 32'(board_full), 1);
      chk("full_valid", 32'(food_valid), 0);
      chk("full_food_held", 32'({food_x, food_y}), 32'h20);
      chk("full_pulses", pulses - p, 4);
      fill_occ(0);
      seq[rng_idx] = 8'h35;
      do_req(0, n);
      chk("full_cleared", 32'(board_full), 0);
      seq[rng_idx] = 8'h35; p = pulses;
      do_req(2, n);
      chk("busy_req_pulses", pulses - p, 1);
      seq[rng_idx] = 8'h35; p = pulses;
      do_req(5, n);
      repeat (3) @(negedge system_clk);
      chk("commit_req_idle", 32'(busy), 0);
      chk("commit_req_pulses", pulses - p, 1);
      for (int r = 0; r < 40; r++) begin
         fill_occ($urandom_range(0, 3) * 33 + (r % 5 == 4 ? 1 : 0));
         do_req($urandom_range(0, 8), n);
         repeat ($urandom_range(0, 3)) @(negedge system_clk);
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end
endmodule
